// File: rtl/seg7_scan_decoder.sv
// Receive side of the 7-segment driver path: debounces the multiplexed
// active-low display bus and rebuilds the shown hex word once per full scan.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        DP,
    output logic [31:0] value,
    output logic [7:0]  dp_mask,
    output logic [7:0]  blank_mask,
    output logic        err,
    output logic        frame_valid
);

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    // {ok, nibble}; ok is 0 for any pattern outside the hex font
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E: r = 5'h10;  7'h30: r = 5'h11;  7'h6D: r = 5'h12;  7'h79: r = 5'h13;
            7'h33: r = 5'h14;  7'h5B: r = 5'h15;  7'h5F: r = 5'h16;  7'h70: r = 5'h17;
            7'h7F: r = 5'h18;  7'h7B: r = 5'h19;  7'h77: r = 5'h1A;  7'h1F: r = 5'h1B;
            7'h4E: r = 5'h1C;  7'h3D: r = 5'h1D;  7'h4F: r = 5'h1E;  7'h47: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [15:0] pin_d, pin_q;
    logic        hist_d, hist_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [31:0] shadow_val_d, shadow_val_q;
    logic [7:0]  shadow_dp_d, shadow_dp_q;
    logic [7:0]  shadow_blank_d, shadow_blank_q;
    logic        shadow_err_d, shadow_err_q;
    logic [7:0]  seen_d, seen_q;
    logic [31:0] value_d, value_q;
    logic [7:0]  dp_mask_d, dp_mask_q;
    logic [7:0]  blank_mask_d, blank_mask_q;
    logic        err_d, err_q;
    logic        frame_valid_d, frame_valid_q;

    logic        same;
    logic        commit;
    logic [7:0]  sel;
    logic [6:0]  seg;
    logic        dp_lit;
    logic        one_hot;
    logic [4:0]  dec;

    assign sel    = pin_q[15:8];
    assign seg    = pin_q[7:1];
    assign dp_lit = pin_q[0];

    always_comb begin
        pin_d   = {~AN, ~CA, ~CB, ~CC, ~CD, ~CE, ~CF, ~CG, ~DP};
        hist_d  = 1'b1;
        // hist_q masks the compare on the first sample after reset
        same    = hist_q && (pin_d == pin_q);
        commit  = same && (cnt_q == SETTLE - 8'd1);
        if (!same)
            cnt_d = 8'd0;
        else if (cnt_q == SETTLE)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;
        one_hot = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
        dec     = decode_seg(seg);
    end

    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        shadow_err_d   = shadow_err_q;
        seen_d         = seen_q;
        value_d        = value_q;
        dp_mask_d      = dp_mask_q;
        blank_mask_d   = blank_mask_q;
        err_d          = err_q;
        frame_valid_d  = 1'b0;

        if (seen_q == 8'hFF) begin
            value_d       = shadow_val_q;
            dp_mask_d     = shadow_dp_q;
            blank_mask_d  = shadow_blank_q;
            err_d         = shadow_err_q;
            frame_valid_d = 1'b1;
            seen_d        = 8'd0;
            shadow_err_d  = 1'b0;
        end

        // applied after the publish so a same-edge commit lands in the new frame
        if (commit) begin
            if (one_hot) begin
                for (int i = 0; i < 8; i++) begin
                    if (sel[i]) begin
                        shadow_val_d[4*i +: 4] = dec[4] ? dec[3:0] : 4'h0;
                        shadow_blank_d[i]      = (seg == 7'h00);
                        shadow_dp_d[i]         = dp_lit;
                        seen_d[i]              = 1'b1;
                        if (!dec[4] && seg != 7'h00)
                            shadow_err_d = 1'b1;
                    end
                end
            end else if (sel != 8'd0) begin
                shadow_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            pin_q          <= '0;
            hist_q         <= 1'b0;
            cnt_q          <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            shadow_err_q   <= 1'b0;
            seen_q         <= '0;
            value_q        <= '0;
            dp_mask_q      <= '0;
            blank_mask_q   <= '0;
            err_q          <= 1'b0;
            frame_valid_q  <= 1'b0;
        end else begin
            pin_q          <= pin_d;
            hist_q         <= hist_d;
            cnt_q          <= cnt_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_err_q   <= shadow_err_d;
            seen_q         <= seen_d;
            value_q        <= value_d;
            dp_mask_q      <= dp_mask_d;
            blank_mask_q   <= blank_mask_d;
            err_q          <= err_d;
            frame_valid_q  <= frame_valid_d;
        end
    end

    assign value       = value_q;
    assign dp_mask     = dp_mask_q;
    assign blank_mask  = blank_mask_q;
    assign err         = err_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives the active-low display bus
// and compares each published frame against hand-computed values.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  an;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [31:0] value;
    logic [7:0]  dp_mask, blank_mask;
    logic        err, frame_valid;

    int n_vec  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int e0_cyc = 0;
    int base;

    seg7_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .AN         (an),
        .CA         (ca),
        .CB         (cb),
        .CC         (cc),
        .CD         (cd),
        .CE         (ce),
        .CF         (cf),
        .CG         (cg),
        .DP         (dp),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .err        (err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pins(input logic [7:0] a, input logic [6:0] s, input logic d);
        an = a;
        {ca, cb, cc, cd, ce, cf, cg} = ~s;
        dp = ~d;
    endtask

    // pins held for n rising edges; e0_cyc marks the first of them
    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        set_pins(a, s, d);
        e0_cyc = cyc + 1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int i, input logic [3:0] nib, input logic d, input int n);
        hold(~(8'd1 << i), enc(nib), d, n);
    endtask

    task automatic scan(input logic [31:0] v, input int n);
        for (int i = 0; i < 8; i++) digit(i, v[4*i +: 4], 1'b0, n);
    endtask

    task automatic idle(input int n);
        hold(8'hFF, 7'h00, 1'b0, n);
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] v, input logic [7:0] dpm,
                             input logic [7:0] bm, input logic e);
        chk({tag, "_value"}, value, v);
        chk({tag, "_dp"}, {24'd0, dp_mask}, {24'd0, dpm});
        chk({tag, "_blank"}, {24'd0, blank_mask}, {24'd0, bm});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    endtask

    initial begin
        reset = 1'b1;
        set_pins(8'hFF, 7'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_frame("rst", 32'h0, 8'h00, 8'h00, 1'b0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        reset = 1'b0;
        idle(5);

        // basic frame plus pin-to-frame_valid latency
        base = fv_cnt;
        scan(32'h76543210, 10);
        chk("t1_latency", 32'(fv_cyc - e0_cyc), 32'd5);
        idle(3);
        chk("t1_nfv", 32'(fv_cnt - base), 32'd1);
        chk_frame("t1", 32'h76543210, 8'h00, 8'h00, 1'b0);

        // full hex, DP on digit 2, blank digit 7
        base = fv_cnt;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] v2;
            v2 = 32'h08FEDCBA;
            digit(i, v2[4*i +: 4], (i == 2), 10);
        end
        hold(8'h7F, 7'h00, 1'b0, 10);
        idle(3);
        chk("t2_nfv", 32'(fv_cnt - base), 32'd1);
        chk_frame("t2", 32'h08FEDCBA, 8'h04, 8'h80, 1'b0);

        // short stray pattern is ignored
        base = fv_cnt;
        hold(8'hFE, enc(4'h5), 1'b0, 3);
        digit(0, 4'h9, 1'b0, 10);
        for (int i = 1; i < 8; i++) digit(i, 4'h0, 1'b0, 10);
        idle(3);
        chk("t3_nfv", 32'(fv_cnt - base), 32'd1);
        chk_frame("t3", 32'h00000009, 8'h00, 8'h00, 1'b0);

        // invalid segment pattern on digit 3
        base = fv_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) hold(8'hF7, 7'h01, 1'b0, 10);
            else        digit(i, 4'(i), 1'b0, 10);
        end
        idle(3);
        chk("t4a_nfv", 32'(fv_cnt - base), 32'd1);
        chk_frame("t4a", 32'h76540210, 8'h00, 8'h00, 1'b1);

        // two digits enabled at once
        hold(8'hFC, enc(4'h1), 1'b0, 10);
        scan(32'h11111111, 10);
        idle(3);
        chk_frame("t4b", 32'h11111111, 8'h00, 8'h00, 1'b1);

        scan(32'h22222222, 10);
        idle(3);
        chk_frame("t4c", 32'h22222222, 8'h00, 8'h00, 1'b0);

        // overwrite of digit 0, then back-to-back scan into the next frame
        base = fv_cnt;
        digit(0, 4'h1, 1'b0, 10);
        digit(0, 4'h5, 1'b0, 10);
        for (int i = 1; i < 8; i++) digit(i, 4'(i), 1'b0, 10);
        chk("t5a_nfv", 32'(fv_cnt - base), 32'd1);
        chk("t5a_value", value, 32'h76543215);
        digit(0, 4'h8, 1'b0, 10);
        for (int i = 1; i < 8; i++) digit(i, 4'h9, 1'b0, 10);
        idle(3);
        chk("t5b_nfv", 32'(fv_cnt - base), 32'd2);
        chk("t5b_value", value, 32'h99999998);

        // dwell boundary: 4 edges ignored, 5 edges accepted
        base = fv_cnt;
        for (int i = 0; i < 7; i++) digit(i, 4'h3, 1'b0, 10);
        digit(7, 4'h3, 1'b0, 4);
        idle(10);
        chk("dwell4_nfv", 32'(fv_cnt - base), 32'd0);
        digit(7, 4'h3, 1'b0, 5);
        idle(3);
        chk("dwell5_nfv", 32'(fv_cnt - base), 32'd1);
        chk("dwell5_value", value, 32'h33333333);

        // reset mid-frame
        for (int i = 0; i < 4; i++) digit(i, 4'hF, 1'b0, 10);
        reset = 1'b1;
        set_pins(8'hFF, 7'h00, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_frame("t6_rst", 32'h0, 8'h00, 8'h00, 1'b0);
        chk("t6_rst_fv", {31'd0, frame_valid}, 32'd0);
        base = fv_cnt;
        for (int i = 4; i < 8; i++) digit(i, 4'(i), 1'b0, 10);
        idle(5);
        chk("t6_partial_nfv", 32'(fv_cnt - base), 32'd0);
        for (int i = 0; i < 4; i++) digit(i, 4'(i), 1'b0, 10);
        idle(3);
        chk("t6_nfv", 32'(fv_cnt - base), 32'd1);
        chk_frame("t6", 32'h76543210, 8'h00, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
